// File: rtl/exec_pkg.sv
// Shared definitions for the execute/write-back stage: opcode encodings,
// FSM state encoding and the shift-amount width.
package exec_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Bundle of the instruction handshake and the register-file port pair used
// by exec_unit. The slave side is the execute unit; the master side is the
// instruction issuer plus register file.
interface exec_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic [2:0]            opcode;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  ready;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reg_write;

    modport master (
        output start, opcode, rs1, rs2, rd, read_data1, read_data2,
        input  ready, done, result, read_reg1, read_reg2,
               write_reg, write_data, reg_write
    );

    modport slave (
        input  start, opcode, rs1, rs2, rd, read_data1, read_data2,
        output ready, done, result, read_reg1, read_reg2,
               write_reg, write_data, reg_write
    );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for exec_unit. Shifts move one bit per use in the
// default build, or the full amount b[4:0] when EXEC_FAST_SHIFT_EN is
// defined (barrel shifter).
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    logic [SHAMT_W-1:0] shamt;

`ifdef EXEC_FAST_SHIFT_EN
    assign shamt = b[SHAMT_W-1:0];
`else
    assign shamt = SHAMT_W'(1);
`endif

    // Select the arithmetic/logic result or one shift step for the opcode
    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $unsigned($signed(a) >>> shamt);
            default: y = a;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back stage: IDLE -> READ -> EXEC (1..31 cycles)
// -> WB. Operands come from the register file read ports, the result goes
// back through its single write port. Define EXEC_FAST_SHIFT_EN to finish
// shifts in a single EXEC cycle.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic         clk,
    input logic         reset,
    exec_unit_if.slave  bus
);

    state_t                state;
    state_t                next_state;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] opb;
    logic [DATA_WIDTH-1:0] result_q;
    logic [SHAMT_W-1:0]    cnt;
    logic [DATA_WIDTH-1:0] alu_y;
    logic                  last_step;

    exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op (op_q),
        .a  (acc),
        .b  (opb),
        .y  (alu_y)
    );

`ifdef EXEC_FAST_SHIFT_EN
    assign last_step = 1'b1;
`else
    assign last_step = (cnt <= SHAMT_W'(1));
`endif

    // State register; reset returns the unit to IDLE
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; EXEC leaves once the counter will have reached zero
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = READ;
            READ:    next_state = EXEC;
            EXEC:    if (last_step) next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Instruction latch, operand capture, shift iteration and result update
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.opcode;
                        rs1_q <= bus.rs1;
                        rs2_q <= bus.rs2;
                        rd_q  <= bus.rd;
                    end
                end
                READ: begin
                    acc <= bus.read_data1;
                    opb <= bus.read_data2;
                    cnt <= is_shift(op_q) ? bus.read_data2[SHAMT_W-1:0] : '0;
                end
                EXEC: begin
                    if (!is_shift(op_q)) begin
                        acc <= alu_y;
                    end else begin
`ifdef EXEC_FAST_SHIFT_EN
                        acc <= alu_y;
                        cnt <= '0;
`else
                        if (cnt != '0) begin
                            acc <= alu_y;
                            cnt <= cnt - SHAMT_W'(1);
                        end
`endif
                    end
                end
                WB: begin
                    result_q <= acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = (state == IDLE);
    assign bus.done       = (state == WB) && !reset;
    assign bus.reg_write  = (state == WB) && (rd_q != '0) && !reset;
    assign bus.write_reg  = (state == WB) ? rd_q : '0;
    assign bus.write_data = (state == WB) ? acc : '0;
    assign bus.read_reg1  = (state == IDLE) ? '0 : rs1_q;
    assign bus.read_reg2  = (state == IDLE) ? '0 : rs2_q;
    assign bus.result     = result_q;

endmodule
